// File: rtl/aes_spi_master.sv
// SPI master for one AES decryption slave frame: shifts {ciphertext, key}
// out MSB-first with cs low, idles through the slave's decrypt latency, then
// shifts the 128-bit plaintext back in from miso and presents it on text_out.
//
// Handshake: start is a request sampled only in IDLE. The edge that sees
// start=1 in IDLE accepts it, and busy goes high on that edge. While busy=1,
// start is ignored and text_in/key_in are not re-latched. done pulses for one
// cycle, and busy is already low in that cycle, so a start held high in the
// done cycle begins the next frame with exactly one cs-high cycle between
// frames.
module aes_spi_master #(
  parameter int NK          = 4,
  parameter int WAIT_CYCLES = 54
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [127:0]      text_in,
  input  logic [32*NK-1:0]  key_in,
  output logic              cs,
  output logic              mosi,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [127:0]      text_out,
  output logic [1:0]        state_dbg
);

  localparam int T      = 128 + 32*NK;
  localparam int CMAX   = (T > WAIT_CYCLES) ? T : WAIT_CYCLES;
  localparam int CW_RAW = $clog2(CMAX + 1);
  localparam int CW     = (CW_RAW < 9) ? 9 : CW_RAW;
  localparam int WLAST  = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  localparam logic [CW-1:0] C_T     = CW'(T);
  localparam logic [CW-1:0] C_WLAST = CW'(WLAST);
  localparam logic [CW-1:0] C_RLAST = CW'(127);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_RECV = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  // The first TX bit goes straight from text_in[127] to mosi on the accept
  // edge, so only the remaining T-1 bits need to be held for shifting.
  logic [T-2:0]     r_tx;
  // The last plaintext bit is taken directly from miso on the final edge,
  // so only the first 127 samples are stored here.
  logic [126:0]     r_rx;
  logic             r_cs;
  logic             r_mosi;
  logic             r_busy;
  logic             r_done;
  logic [127:0]     r_text_out;

  assign cs        = r_cs;
  assign mosi      = r_mosi;
  assign busy      = r_busy;
  assign done      = r_done;
  assign text_out  = r_text_out;
  assign state_dbg = r_state;

  // Frame sequencer: accept, shift out, wait for the slave, shift in, report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cs       <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_text_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tx    <= {text_in[126:0], key_in};
            r_cs    <= 1'b0;
            r_mosi  <= text_in[127];
            r_busy  <= 1'b1;
            r_cnt   <= CW'(1);
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          // r_cnt counts bits already presented; after T of them, stop.
          if (r_cnt == C_T) begin
            r_mosi  <= 1'b0;
            r_cnt   <= '0;
            r_state <= (WAIT_CYCLES == 0) ? S_RECV : S_WAIT;
          end else begin
            r_mosi <= r_tx[T-2];
            r_tx   <= {r_tx[T-3:0], 1'b0};
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (r_cnt == C_WLAST) begin
            r_cnt   <= '0;
            r_state <= S_RECV;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RECV: begin
          r_rx <= {r_rx[125:0], miso};
          if (r_cnt == C_RLAST) begin
            // text_out changes only here, all 128 bits at once.
            r_text_out <= {r_rx, miso};
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_cs       <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
